uart_tx_frame: RTL and testbench

UART transmitter: the serializing counterpart of the UART receive path in the same system.
- Accepts a parallel word with a valid strobe.
- Emits one complete frame on TX_OUT: start bit, DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit.
- CLK is the TX bit clock: one serial bit per CLK cycle.
- Sits between the system controller/TX FIFO read side and the TX pad.

---
 rtl/uart_tx_frame.sv | 98 +++++++++
 tb/tb_uart_tx_frame.sv | 132 +++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// One bit per CLK cycle; TX_OUT and BUSY come straight from flops.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_cnt;
    logic                  r_par_en;
    logic                  r_par;
    logic                  r_tx;
    logic                  r_busy;

    // Output flops are loaded with the value of the state being entered, so the
    // line level always matches the current state with no decode after the flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (DATA_VALID) begin
                        r_shift  <= P_DATA;
                        r_par_en <= PAR_EN;
                        r_par    <= (^P_DATA) ^ PAR_TYP;
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                START: begin
                    r_cnt   <= '0;
                    r_tx    <= r_shift[0];
                    r_shift <= r_shift >> 1;
                    r_state <= DATA;
                end
                DATA: begin
                    if (r_cnt == LAST_BIT) begin
                        if (r_par_en) begin
                            r_tx    <= r_par;
                            r_state <= PARITY;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end
                PARITY: begin
                    r_tx    <= 1'b1;
                    r_state <= STOP;
                end
                STOP: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign BUSY   = r_busy;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-computed frame bit sequences, checked on the falling edge.
module tb_uart_tx_frame;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       DATA_VALID = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       TX_OUT;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Strobe one word: drive at a falling edge, drop after the accepting edge.
    // Returns at the falling edge in the middle of the start bit.
    task automatic send(input logic [7:0] d, input logic pen, input logic ptyp, input logic hold);
        @(negedge CLK);
        P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = hold;
    endtask

    // seq holds the frame in send order, first bit at seq[len-1].
    // inj1/inj2: step indices at which a 0xFF strobe is pulsed mid-frame.
    task automatic expect_frame(input string tag, input logic [10:0] seq, input int len,
                                input int inj1, input int inj2, input logic hold);
        for (int i = 0; i < len; i++) begin
            chk($sformatf("%s tx[%0d]", tag, i), {31'd0, TX_OUT}, {31'd0, seq[len-1-i]});
            chk($sformatf("%s busy[%0d]", tag, i), {31'd0, BUSY}, 32'd1);
            if (i == inj1 || i == inj2) begin
                P_DATA = 8'hFF; DATA_VALID = 1'b1;
            end else begin
                DATA_VALID = hold;
            end
            @(negedge CLK);
        end
        DATA_VALID = hold;
        chk({tag, " idle tx"}, {31'd0, TX_OUT}, 32'd1);
        chk({tag, " idle busy"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        // 1: reset held with strobes toggling, then quiet line after release
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            DATA_VALID = i[0];
            P_DATA = 8'h5A;
            chk("rst tx", {31'd0, TX_OUT}, 32'd1);
            chk("rst busy", {31'd0, BUSY}, 32'd0);
        end
        DATA_VALID = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post-rst tx", {31'd0, TX_OUT}, 32'd1);
            chk("post-rst busy", {31'd0, BUSY}, 32'd0);
        end

        // 2: 0xA5, no parity
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        expect_frame("a5", 11'b0101001011, 10, -1, -1, 1'b0);

        // 3: 0x07 with even parity (bit 1), then odd parity (bit 0)
        send(8'h07, 1'b1, 1'b0, 1'b0);
        expect_frame("07e", 11'b01110000011, 11, -1, -1, 1'b0);
        send(8'h07, 1'b1, 1'b1, 1'b0);
        expect_frame("07o", 11'b01110000001, 11, -1, -1, 1'b0);

        // 4: 0x3C even parity; 0xFF strobes during data bit 3 and STOP are ignored
        send(8'h3C, 1'b1, 1'b0, 1'b0);
        expect_frame("3c", 11'b00011110001, 11, 4, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("3c no-2nd tx", {31'd0, TX_OUT}, 32'd1);
            chk("3c no-2nd busy", {31'd0, BUSY}, 32'd0);
        end

        // 5: strobe held high, back-to-back 0x55 frames with one idle bit between
        send(8'h55, 1'b0, 1'b0, 1'b1);
        expect_frame("55a", 11'b0101010101, 10, -1, -1, 1'b1);
        @(negedge CLK);
        expect_frame("55b", 11'b0101010101, 10, -1, -1, 1'b1);
        @(negedge CLK);
        expect_frame("55c", 11'b0101010101, 10, -1, -1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            chk("55 stop tx", {31'd0, TX_OUT}, 32'd1);
        end

        // 6: async reset during data bit 4 of 0x00, then a clean frame
        send(8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("00 tx[%0d]", i), {31'd0, TX_OUT}, 32'd0);
            @(negedge CLK);
        end
        chk("00 bit4 tx", {31'd0, TX_OUT}, 32'd0);
        chk("00 bit4 busy", {31'd0, BUSY}, 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("async rst tx", {31'd0, TX_OUT}, 32'd1);
        chk("async rst busy", {31'd0, BUSY}, 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        chk("held rst tx", {31'd0, TX_OUT}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rel tx", {31'd0, TX_OUT}, 32'd1);
        chk("rel busy", {31'd0, BUSY}, 32'd0);
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        expect_frame("a5r", 11'b0101001011, 10, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
